// File: rtl/incubator_pkg.sv
// Shared types and constants for the incubator controller and its plant model.
package incubator_pkg;

  localparam int TEMP_W = 8;

  typedef logic [TEMP_W-1:0] temp_t;
  // Wide enough for temperature plus or minus any single-tick step, without wrapping.
  typedef logic signed [TEMP_W+1:0] delta_t;

  localparam logic [3:0] CRS_OFF  = 4'd0;
  localparam logic [3:0] CRS_LOW  = 4'd4;
  localparam logic [3:0] CRS_MID  = 4'd6;
  localparam logic [3:0] CRS_HIGH = 4'd8;

  localparam int T_INIT_DEF    = 25;
  localparam int T_AMBIENT_DEF = 25;

  // Saturate a signed intermediate temperature into [lo, hi].
  function automatic temp_t clamp_temp(input delta_t v, input int lo, input int hi);
    if (v < delta_t'(lo)) return temp_t'(lo);
    if (v > delta_t'(hi)) return temp_t'(hi);
    return temp_t'(v);
  endfunction

endpackage

// File: rtl/incubator_plant_prescaler.sv
// Free-running divider: pulses tick while the count sits at DIV-1; clr restarts from 0.
module tick_prescaler #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/incubator_plant.sv
// Thermal plant model: integrates actuator effects once per tick, drifts to ambient
// when idle, saturates at the range limits and accepts forced loads.
module incubator_plant
  import incubator_pkg::*;
#(
  parameter int T_INIT    = T_INIT_DEF,
  parameter int T_AMBIENT = T_AMBIENT_DEF,
  parameter int T_MIN     = 0,
  parameter int T_MAX     = 60,
  parameter int TICK_DIV  = 16,
  parameter int DRIFT_DIV = 4,
  parameter int HEAT_STEP = 2,
  parameter int COOL_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              heater,
  input  logic              cooler,
  input  logic [3:0]        crs,
  input  logic              load_en,
  input  logic [TEMP_W-1:0] load_val,
  output logic [TEMP_W-1:0] t,
  output logic              tick,
  output logic              fault
);

  localparam int DCW = (DRIFT_DIV > 1) ? $clog2(DRIFT_DIV + 1) : 1;

  logic           tick_int;
  temp_t          t_q, t_d;
  logic           tick_q, tick_d;
  logic           fault_q, fault_d;
  logic [DCW-1:0] drift_q, drift_d;

  logic   both, idle;
  delta_t delta, sum;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load_en),
    .tick (tick_int)
  );

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latches).
    t_d     = t_q;
    tick_d  = 1'b0;
    fault_d = fault_q;
    drift_d = drift_q;

    both  = heater && cooler;
    idle  = !heater && !cooler && (crs == CRS_OFF);
    delta = -delta_t'(crs >> 1);
    // A conflicting heater/cooler request cancels both contributions for that tick.
    if (heater && !both) delta = delta + delta_t'(HEAT_STEP);
    if (cooler && !both) delta = delta - delta_t'(COOL_STEP);
    sum = delta_t'({2'b00, t_q}) + delta;

    if (load_en) begin
      t_d     = clamp_temp(delta_t'({2'b00, load_val}), T_MIN, T_MAX);
      drift_d = '0;
    end else if (tick_int) begin
      tick_d  = 1'b1;
      fault_d = fault_q || both;
      if (idle) begin
        if (drift_q == DCW'(DRIFT_DIV - 1)) begin
          drift_d = '0;
          if (t_q > temp_t'(T_AMBIENT))      t_d = t_q - 1'b1;
          else if (t_q < temp_t'(T_AMBIENT)) t_d = t_q + 1'b1;
        end else begin
          drift_d = drift_q + 1'b1;
        end
      end else begin
        drift_d = '0;
        t_d     = clamp_temp(sum, T_MIN, T_MAX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q     <= temp_t'(T_INIT);
      tick_q  <= 1'b0;
      fault_q <= 1'b0;
      drift_q <= '0;
    end else begin
      t_q     <= t_d;
      tick_q  <= tick_d;
      fault_q <= fault_d;
      drift_q <= drift_d;
    end
  end

  assign t     = t_q;
  assign tick  = tick_q;
  assign fault = fault_q;

endmodule

// File: tb/tb_incubator_plant.sv
// Directed bench for incubator_plant with TICK_DIV=4, DRIFT_DIV=3.
module tb_incubator_plant;
  import incubator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       heater, cooler;
  logic [3:0] crs;
  logic       load_en;
  logic [7:0] load_val;
  logic [7:0] t;
  logic       tick, fault;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cur_t;

  incubator_plant #(
    .TICK_DIV  (4),
    .DRIFT_DIV (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .heater   (heater),
    .cooler   (cooler),
    .crs      (crs),
    .load_en  (load_en),
    .load_val (load_val),
    .t        (t),
    .tick     (tick),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Three quiet cycles with t held, then the tick update edge.
  task automatic expect_tick(input logic [7:0] exp);
    repeat (3) begin
      step();
      check("hold_t", t, cur_t);
      check("no_tick", {7'b0, tick}, 8'd0);
    end
    step();
    check("tick_pulse", {7'b0, tick}, 8'd1);
    check("tick_t", t, exp);
    cur_t = exp;
  endtask

  task automatic load(input logic [7:0] val, input logic [7:0] exp);
    load_en  = 1'b1;
    load_val = val;
    step();
    load_en  = 1'b0;
    check("load_t", t, exp);
    check("load_no_tick", {7'b0, tick}, 8'd0);
    cur_t = exp;
  endtask

  initial begin
    rst = 1'b0; heater = 1'b1; cooler = 1'b0; crs = CRS_OFF;
    load_en = 1'b0; load_val = 8'd0;
    step();
    check("rst_t", t, 8'd25);
    check("rst_tick", {7'b0, tick}, 8'd0);
    check("rst_fault", {7'b0, fault}, 8'd0);
    rst = 1'b1;
    cur_t = 8'd25;

    // Heating ramp
    expect_tick(8'd27);
    expect_tick(8'd29);
    expect_tick(8'd31);

    // Cooler plus high fan: -5 per tick
    heater = 1'b0; cooler = 1'b1; crs = CRS_HIGH;
    load(8'd40, 8'd40);
    expect_tick(8'd35);
    expect_tick(8'd30);
    expect_tick(8'd25);
    check("cool_fault", {7'b0, fault}, 8'd0);

    // Saturation at both limits
    cooler = 1'b0; crs = CRS_OFF; heater = 1'b1;
    load(8'd59, 8'd59);
    expect_tick(8'd60);
    expect_tick(8'd60);
    load(8'd200, 8'd60);
    heater = 1'b0; crs = CRS_MID;
    load(8'd1, 8'd1);
    expect_tick(8'd0);
    expect_tick(8'd0);

    // Ambient drift downward, one degree per three idle ticks
    crs = CRS_OFF;
    load(8'd30, 8'd30);
    for (int i = 1; i <= 18; i++) begin
      int e;
      e = 30 - i / 3;
      if (e < 25) e = 25;
      expect_tick(8'(e));
    end

    // A non-idle tick restarts the drift count
    load(8'd30, 8'd30);
    expect_tick(8'd30);
    expect_tick(8'd30);
    crs = CRS_LOW;
    expect_tick(8'd28);
    crs = CRS_OFF;
    expect_tick(8'd28);
    expect_tick(8'd28);
    expect_tick(8'd27);

    // Drift upward from below ambient
    load(8'd20, 8'd20);
    expect_tick(8'd20);
    expect_tick(8'd20);
    expect_tick(8'd21);

    // Conflicting actuators: fault sets, only the fan term applies
    check("pre_fault", {7'b0, fault}, 8'd0);
    load(8'd30, 8'd30);
    heater = 1'b1; cooler = 1'b1; crs = CRS_LOW;
    expect_tick(8'd28);
    check("fault_set", {7'b0, fault}, 8'd1);
    heater = 1'b0; cooler = 1'b0; crs = CRS_OFF;
    expect_tick(8'd28);
    check("fault_sticky", {7'b0, fault}, 8'd1);

    // Asynchronous reset mid-count
    load(8'd45, 8'd45);
    step();
    step();
    rst = 1'b0;
    #2;
    check("async_rst_t", t, 8'd25);
    check("async_rst_fault", {7'b0, fault}, 8'd0);
    check("async_rst_tick", {7'b0, tick}, 8'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cur_t = 8'd25;
    expect_tick(8'd25);

    // Load on the tick cycle wins and restarts the prescaler
    heater = 1'b1;
    repeat (3) begin
      step();
      check("pre_load_no_tick", {7'b0, tick}, 8'd0);
    end
    load(8'd50, 8'd50);
    expect_tick(8'd52);
    check("end_fault", {7'b0, fault}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
